lcd_refresh_engine: RTL
=======================

Name: lcd_refresh_engine

Overview:
Parametrised character-LCD driver (HD44780-class, 8-bit write-only bus) with integrated EN-pulse timing. It replaces the fixed 16x2, one-shot display path with a configurable ROWS x COLS engine. The engine initialises the panel once after reset, then rewrites the full screen on request through an iUpdate/oBusy/oDone handshake. It sits between the cipher datapath (which supplies ASCII text) and the board LCD pins.

Parameters:
COLS, 16, characters per row (1..20)
ROWS, 2, display rows (1..4)
EN_PULSE, 16, cycles LCD_EN held high per write (>=1)
DLY_CYCLES, 262142, post-write settle cycles with LCD_EN low (>=1)
DLY_W, 18, width of the settle counter; must hold DLY_CYCLES

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iChars  in  ROWS*COLS*8  ASCII text; row 0 col 0 = MSB byte, row-major
iUpdate  in  1  refresh request, level- or pulse-sampled each cycle
oBusy  out  1  high while init or refresh is in progress
oDone  out  1  one-cycle pulse at the end of each refresh
LCD_DATA  out  8  panel data bus
LCD_RW  out  1  tied 0 (write only)
LCD_EN  out  1  panel enable strobe
LCD_RS  out  1  0 = command, 1 = character data

Behaviour:
- Clock and reset: one clock, iCLK. Reset is asynchronous and active-low on iRST_N.
- Reset values: LCD_DATA=0, LCD_RS=0, LCD_EN=0, LCD_RW=0, oDone=0, oBusy=1, pending=0, all counters 0, state=INIT.
- Write cell (every command and character uses this sequence), period = 1+EN_PULSE+DLY_CYCLES cycles:
  - SETUP: 1 cycle. LCD_DATA and LCD_RS are driven; EN stays low.
  - EN_HI: EN_PULSE cycles with EN=1.
  - SETTLE: DLY_CYCLES cycles with EN=0.
  - LCD_DATA and LCD_RS stay stable from SETUP through the end of SETTLE.
- INIT: four commands in this order: 0x38, 0x0C, 0x01, 0x06 (RS=0). INIT is followed by an automatic refresh. No iUpdate is needed for this refresh.
- Refresh:
  - On entry, iChars is snapshotted into an internal buffer. Input changes after the snapshot do not affect the refresh in progress.
  - For each row r = 0..ROWS-1: first the address command (RS=0) 0x80, 0xC0, 0x94 or 0xD4 for r = 0, 1, 2, 3; then COLS characters (RS=1) from the snapshot.
  - Total writes per refresh: ROWS*(COLS+1).
- IDLE:
  - oBusy=0.
  - iUpdate=1 → enter refresh on the next cycle, with oBusy=1 from that cycle.
- Request while busy:
  - iUpdate=1 during INIT or a refresh sets pending.
  - Any number of requests collapse into one pending refresh.
- End of refresh (final SETTLE done):
  - oDone=1 for exactly one cycle.
  - If pending, or iUpdate=1 in that same cycle: clear pending and start a new refresh on the next cycle with a new snapshot; oBusy stays 1.
  - Otherwise go to IDLE with oBusy=0 in the cycle after the oDone pulse.
- oDone also pulses at the end of the automatic post-INIT refresh.
- Reset mid-operation: EN drops to 0 immediately (asynchronous). All state is discarded, including pending and the snapshot. The full INIT sequence runs again after release.
- Counters: character and row indices wrap to 0 at the row and frame ends. There is no out-of-range indexing for any legal ROWS/COLS.
- LCD_RW is constant 0. The engine never reads the panel's busy flag.

Test Plan:
Parameters for all cases: COLS=4, ROWS=2, EN_PULSE=2, DLY_CYCLES=3, giving a 6-cycle write cell.
1. Reset release, iChars="ABCDEFGH":
   - Bus sequence is 38,0C,01,06, then 80,'A','B','C','D', then C0,'E','F','G','H'.
   - RS pattern is 0000 0 1111 0 1111.
   - oDone pulses exactly 84 cycles after release.
   - oBusy=0 on the following cycle.
2. Timing check: every write holds EN=1 for exactly 2 cycles, preceded by 1 setup cycle and followed by 3 low cycles. Data is stable across the whole cell.
3. Idle, iUpdate pulse, and iChars changed 2 cycles after the pulse:
   - oBusy rises on the next cycle.
   - The displayed text equals the value at the pulse.
   - oDone fires 60 cycles later.
4. Three iUpdate pulses during one refresh:
   - Exactly one extra refresh follows, back-to-back.
   - oBusy stays high between the two refreshes.
   - Two oDone pulses total.
5. Assert iRST_N low in the middle of an EN_HI phase:
   - EN=0 combinationally.
   - After release the bus restarts with 0x38.
   - The earlier pending request is not serviced.
6. ROWS=4, COLS=20 build:
   - Address commands appear as 80, C0, 94, D4.
   - 84 writes per refresh.

Source files
------------

// File: rtl/lcd_refresh_engine.sv
// lcd_refresh_engine: HD44780-class character LCD driver (8-bit, write-only)
// with built-in EN strobe timing. Initialises the panel once after reset,
// then rewrites the whole ROWS x COLS screen on request.
//
// Ports:
//   iCLK      system clock
//   iRST_N    asynchronous active-low reset
//   iChars    ROWS*COLS ASCII bytes, row 0 col 0 in the MSB byte, row-major
//   iUpdate   refresh request, sampled every cycle
//   oBusy     high while init or a refresh is running
//   oDone     one-cycle pulse in the last settle cycle of each refresh
//   LCD_DATA  panel data bus
//   LCD_RW    always 0 (write only)
//   LCD_EN    panel enable strobe
//   LCD_RS    0 = command, 1 = character data
module lcd_refresh_engine #(
   parameter int COLS       = 16,
   parameter int ROWS       = 2,
   parameter int EN_PULSE   = 16,
   parameter int DLY_CYCLES = 262142,
   parameter int DLY_W      = 18
) (
   input  logic                   iCLK,
   input  logic                   iRST_N,
   input  logic [ROWS*COLS*8-1:0] iChars,
   input  logic                   iUpdate,
   output logic                   oBusy,
   output logic                   oDone,
   output logic [7:0]             LCD_DATA,
   output logic                   LCD_RW,
   output logic                   LCD_EN,
   output logic                   LCD_RS
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = $clog2(COLS + 1);
   localparam int TW = (DLY_W > $clog2(EN_PULSE + 1)) ? DLY_W : $clog2(EN_PULSE + 1);
   localparam logic [TW-1:0] EN_LAST  = TW'(EN_PULSE - 1);
   localparam logic [TW-1:0] DLY_LAST = TW'(DLY_CYCLES - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS);

   typedef enum logic [2:0] {INIT, SETUP, EN_HI, SETTLE, IDLE} state_t;

   state_t                 state, stateN;
   logic [TW-1:0]          tmr, tmrN;
   logic                   initMode, initModeN;
   logic [1:0]             initIdx, initIdxN;
   logic [RW-1:0]          row, rowN;
   // col 0 is the row address command, cols 1..COLS are the characters
   logic [CW-1:0]          col, colN;
   logic                   pending, pendingN;
   logic [ROWS*COLS*8-1:0] snap;
   logic                   load, startRef, rsN;
   logic [7:0]             dataN;
   logic [1:0]             rowSel;
   int                     charIdx;

   assign oBusy  = state != IDLE;
   assign LCD_EN = state == EN_HI;
   assign LCD_RW = 1'b0;

   always_comb begin
      stateN    = state;
      tmrN      = tmr;
      initModeN = initMode;
      initIdxN  = initIdx;
      rowN      = row;
      colN      = col;
      pendingN  = pending | (iUpdate && state != IDLE);
      load      = 1'b0;
      startRef  = 1'b0;
      oDone     = 1'b0;
      case (state)
         INIT:   load = 1'b1;
         IDLE:   startRef = iUpdate;
         SETUP:  begin
            stateN = EN_HI;
            tmrN   = '0;
         end
         EN_HI:  if (tmr == EN_LAST) begin
            stateN = SETTLE;
            tmrN   = '0;
         end else tmrN = tmr + 1'b1;
         SETTLE: if (tmr != DLY_LAST) tmrN = tmr + 1'b1;
            else if (initMode) begin
               if (initIdx == 2'd3) startRef = 1'b1;
               else begin
                  initIdxN = initIdx + 1'b1;
                  load     = 1'b1;
               end
            end else if (col != COL_LAST) begin
               colN = col + 1'b1;
               load = 1'b1;
            end else if (row != ROW_LAST) begin
               rowN = row + 1'b1;
               colN = '0;
               load = 1'b1;
            end else begin
               // frame complete: a queued or same-cycle request restarts at once
               oDone    = 1'b1;
               pendingN = 1'b0;
               startRef = pending | iUpdate;
               stateN   = IDLE;
            end
         default: stateN = INIT;
      endcase
      if (startRef) begin
         initModeN = 1'b0;
         rowN      = '0;
         colN      = '0;
         load      = 1'b1;
      end
      if (load) begin
         stateN = SETUP;
         tmrN   = '0;
      end
      // bus value for the write being launched, taken from the advanced indices
      rowSel  = 2'(rowN);
      charIdx = (colN == '0) ? 0 : ROWS*COLS - int'(rowN)*COLS - int'(colN);
      rsN     = !initModeN && colN != '0;
      dataN   = initModeN ? (initIdxN == 2'd0 ? 8'h38 : initIdxN == 2'd1 ? 8'h0C :
                             initIdxN == 2'd2 ? 8'h01 : 8'h06) :
                (colN == '0) ? (rowSel == 2'd0 ? 8'h80 : rowSel == 2'd1 ? 8'hC0 :
                                rowSel == 2'd2 ? 8'h94 : 8'hD4) :
                snap[charIdx*8 +: 8];
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state    <= INIT;
         tmr      <= '0;
         initMode <= 1'b1;
         initIdx  <= '0;
         row      <= '0;
         col      <= '0;
         pending  <= 1'b0;
         snap     <= '0;
         LCD_DATA <= '0;
         LCD_RS   <= 1'b0;
      end else begin
         state    <= stateN;
         tmr      <= tmrN;
         initMode <= initModeN;
         initIdx  <= initIdxN;
         row      <= rowN;
         col      <= colN;
         pending  <= pendingN;
         if (startRef) snap <= iChars;
         if (load) begin
            LCD_DATA <= dataN;
            LCD_RS   <= rsN;
         end
      end
   end
endmodule
